// File: rtl/sub_refill.sv
// Sub-SRAM refill engine: copies one SUB_DEPTH-word block from flash into a victim sub-SRAM.
// Define REFILL_TIMEOUT_EN to abort a stalled flash read after TIMEOUT idle cycles (fill_err=1).
module sub_refill #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int SUB_DEPTH = 16,
   parameter int SUB_SEL_W = 2,
   parameter int TIMEOUT   = 255
) (
   input  logic                         clk,
   input  logic                         grst,
   input  logic                         fill_req,
   input  logic [ADDR_W-1:0]            fill_base,
   input  logic [SUB_SEL_W-1:0]         fill_sub,
   output logic                         fill_ack,
   output logic                         fill_done,
   output logic                         fill_err,
   output logic                         busy,
   output logic                         flash_req,
   output logic [ADDR_W-1:0]            flash_addr,
   input  logic                         flash_gnt,
   input  logic                         flash_rvalid,
   input  logic [DATA_W-1:0]            flash_rdata,
   output logic                         sram_we,
   output logic [SUB_SEL_W-1:0]         sram_sel,
   output logic [$clog2(SUB_DEPTH)-1:0] sram_waddr,
   output logic [DATA_W-1:0]            sram_wdata
);

   localparam int OFF_W = $clog2(SUB_DEPTH);

   if (SUB_DEPTH < 2 || (1 << OFF_W) != SUB_DEPTH || TIMEOUT < 1) begin : g_bad_params
      $error("sub_refill: SUB_DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
   end

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q;
   logic [SUB_SEL_W-1:0] sub_q;
   logic [OFF_W-1:0]  k_q;
   logic [DATA_W-1:0] data_q;
   logic              early_q;
   logic              accept;
   logic              last_word;
   logic              timeout_hit;

   // Acceptance is gated by grst so no ack can leak out while the block is held in reset.
   assign accept    = (state_q == IDLE) && fill_req && grst;
   assign last_word = (k_q == OFF_W'(SUB_DEPTH - 1));

`ifdef REFILL_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   logic [TMO_W-1:0] tmo_q;
   logic             err_q;
   logic             counting;

   assign counting = ((state_q == ISSUE) && !flash_gnt && !flash_rvalid) ||
                     ((state_q == WAIT) && !flash_rvalid && !early_q);
   assign timeout_hit = counting && (tmo_q == TMO_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge grst) begin
      if (!grst) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= counting ? tmo_q + TMO_W'(1) : '0;
         if (accept)
            err_q <= 1'b0;
         else if (timeout_hit)
            err_q <= 1'b1;
      end
   end

   assign fill_err = (state_q == DONE) && err_q;
`else
   assign timeout_hit = 1'b0;
   assign fill_err    = 1'b0;
`endif

   always_ff @(posedge clk or negedge grst) begin
      if (!grst) begin
         state_q <= IDLE;
         base_q  <= '0;
         sub_q   <= '0;
         k_q     <= '0;
         data_q  <= '0;
         early_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            base_q  <= fill_base & ~ADDR_W'(SUB_DEPTH - 1);
            sub_q   <= fill_sub;
            k_q     <= '0;
            early_q <= 1'b0;
         end
         // Data returned in the grant cycle itself is kept so WAIT can move straight on.
         if ((state_q == ISSUE) && flash_gnt && flash_rvalid) begin
            data_q  <= flash_rdata;
            early_q <= 1'b1;
         end else if ((state_q == WAIT) && flash_rvalid && !early_q) begin
            data_q <= flash_rdata;
         end
         if (state_q == WRITE) begin
            early_q <= 1'b0;
            if (!last_word)
               k_q <= k_q + OFF_W'(1);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = ISSUE;
         ISSUE: begin
            if (timeout_hit)
               state_d = DONE;
            else if (flash_gnt)
               state_d = WAIT;
         end
         WAIT: begin
            if (timeout_hit)
               state_d = DONE;
            else if (flash_rvalid || early_q)
               state_d = WRITE;
         end
         WRITE:   state_d = last_word ? DONE : ISSUE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Buses are forced to zero outside their owning state so reset drives every output low.
   always_comb begin
      fill_ack   = accept;
      fill_done  = (state_q == DONE);
      busy       = (state_q != IDLE) || accept;
      flash_req  = (state_q == ISSUE);
      flash_addr = '0;
      sram_we    = (state_q == WRITE);
      sram_sel   = '0;
      sram_waddr = '0;
      sram_wdata = '0;
      if (state_q == ISSUE)
         flash_addr = base_q + ADDR_W'(k_q);
      if (state_q == WRITE) begin
         sram_sel   = sub_q;
         sram_waddr = k_q;
         sram_wdata = data_q;
      end
   end

endmodule

// File: tb/tb_sub_refill.sv
// Scoreboard bench for sub_refill: directed refills, flash stalls, busy re-requests, address wrap and mid-refill reset.
// Compile with REFILL_TIMEOUT_EN to add the timeout abort scenario.
module tb_sub_refill;

   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;
   localparam int SUB_DEPTH = 16;
   localparam int SUB_SEL_W = 2;

   logic              clk = 1'b0;
   logic              grst;
   logic              fill_req = 1'b0;
   logic [31:0]       fill_base = '0;
   logic [1:0]        fill_sub = '0;
   logic              fill_ack, fill_done, fill_err, busy;
   logic              flash_req;
   logic [31:0]       flash_addr;
   logic              flash_gnt = 1'b0;
   logic              flash_rvalid = 1'b0;
   logic [31:0]       flash_rdata = '0;
   logic              sram_we;
   logic [1:0]        sram_sel;
   logic [3:0]        sram_waddr;
   logic [31:0]       sram_wdata;

   sub_refill #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SUB_DEPTH(SUB_DEPTH),
      .SUB_SEL_W(SUB_SEL_W), .TIMEOUT(8)
   ) dut (
      .clk(clk), .grst(grst),
      .fill_req(fill_req), .fill_base(fill_base), .fill_sub(fill_sub),
      .fill_ack(fill_ack), .fill_done(fill_done), .fill_err(fill_err), .busy(busy),
      .flash_req(flash_req), .flash_addr(flash_addr), .flash_gnt(flash_gnt),
      .flash_rvalid(flash_rvalid), .flash_rdata(flash_rdata),
      .sram_we(sram_we), .sram_sel(sram_sel), .sram_waddr(sram_waddr), .sram_wdata(sram_wdata)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  sel;
      logic [3:0]  waddr;
      logic [31:0] wdata;
   } wr_t;

   typedef struct {
      logic err;
      int   lat;
   } done_t;

   wr_t         exp_wr[$];
   done_t       exp_done[$];
   logic [31:0] exp_addr[$];

   int   n_vec = 0;
   int   n_bad = 0;
   int   cycle = 0;
   int   ack_cycle = 0;
   int   done_cycle = 0;
   int   n_acks = 0;
   int   n_dones = 0;
   int   grant_idx = 0;
   int   stall_word = -1;
   int   stall_len = 0;
   int   stall_cnt = 0;
   bit   no_ack = 1'b0;
   bit   drop_rvalid = 1'b0;
   bit   pend = 1'b0;
   logic [31:0] pend_data = '0;

   always @(posedge clk) cycle <= cycle + 1;

   function automatic logic [31:0] mk_data(input logic [31:0] a);
      return a ^ 32'h5A5A_C3C3;
   endfunction

   task automatic check_output(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor samples one time unit before each rising edge, exactly what the DUT registers.
   always @(negedge clk) begin
      #4;
      if (grst === 1'b1) begin
         if (fill_ack) begin
            check_output("ack_while_busy", fill_ack & no_ack, 0);
            ack_cycle = cycle;
            grant_idx = 0;
            n_acks++;
         end
         if (sram_we) begin
            if (exp_wr.size() == 0)
               check_output("unexpected_write", sram_we, 0);
            else
               check_output("sram_write", {sram_sel, sram_waddr, sram_wdata}, exp_wr.pop_front());
         end
         if (fill_done) begin
            if (exp_done.size() == 0) begin
               check_output("unexpected_done", fill_done, 0);
            end else begin
               done_t d;
               d = exp_done.pop_front();
               check_output("done_err", fill_err, d.err);
               check_output("busy_at_done", busy, 1);
               check_output("done_latency", cycle - ack_cycle, d.lat);
            end
            done_cycle = cycle;
            no_ack = 1'b0;
            n_dones++;
         end
      end
   end

   // Flash model: grants at the negedge of an ISSUE cycle, returns data one cycle later.
   always @(negedge clk) begin
      if (grst !== 1'b1) begin
         flash_gnt    = 1'b0;
         flash_rvalid = 1'b0;
         pend         = 1'b0;
         stall_cnt    = 0;
      end else begin
         flash_rvalid = 1'b0;
         if (pend) begin
            flash_rvalid = !drop_rvalid;
            flash_rdata  = pend_data;
            pend         = 1'b0;
         end
         if (flash_gnt) begin
            flash_gnt = 1'b0;
         end else if (flash_req) begin
            if (exp_addr.size() == 0)
               check_output("unexpected_flash_req", flash_req, 0);
            else
               check_output("flash_addr", flash_addr, exp_addr[0]);
            if (grant_idx == stall_word && stall_cnt < stall_len) begin
               stall_cnt++;
            end else begin
               flash_gnt = 1'b1;
               if (exp_addr.size() != 0)
                  void'(exp_addr.pop_front());
               pend      = 1'b1;
               pend_data = mk_data(flash_addr);
               stall_cnt = 0;
               grant_idx++;
            end
         end
      end
   end

   task automatic push_fill(input logic [31:0] base, input logic [1:0] sub, input int lat);
      logic [31:0] b;
      b = base & 32'hFFFF_FFF0;
      for (int k = 0; k < SUB_DEPTH; k++) begin
         exp_addr.push_back(32'(b + 32'(k)));
         exp_wr.push_back({sub, 4'(k), mk_data(32'(b + 32'(k)))});
      end
      exp_done.push_back('{err: 1'b0, lat: lat});
   endtask

   task automatic wait_ack(input int limit);
      int start;
      start = n_acks;
      for (int i = 0; i < limit && n_acks == start; i++) @(posedge clk);
      if (n_acks == start) check_output("ack_timeout", n_acks - start, 1);
   endtask

   task automatic wait_done(input int limit);
      int start;
      start = n_dones;
      for (int i = 0; i < limit && n_dones == start; i++) @(posedge clk);
      if (n_dones == start) check_output("done_timeout", n_dones - start, 1);
   endtask

   task automatic apply_stimulus(input logic [31:0] base, input logic [1:0] sub, input int lat);
      push_fill(base, sub, lat);
      @(negedge clk);
      fill_base = base;
      fill_sub  = sub;
      fill_req  = 1'b1;
      wait_ack(20);
      @(negedge clk);
      fill_req  = 1'b0;
      fill_base = 32'hDEAD_BEEF;
      fill_sub  = ~sub;
      wait_done(200);
   endtask

   initial begin
      grst = 1'b1;
      #1 grst = 1'b0;
      #1;
      check_output("reset_outputs",
                   {flash_req, flash_addr, sram_we, sram_sel, sram_waddr, sram_wdata,
                    fill_ack, fill_done, fill_err, busy}, 0);
      repeat (3) @(negedge clk);
      grst = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] zero-wait refill base 0x1234 sub 2");
      apply_stimulus(32'h0000_1234, 2'd2, 49);

      $display("[TB] grant stalled 5 cycles on word 3");
      stall_word = 3;
      stall_len  = 5;
      apply_stimulus(32'h0000_8007, 2'd1, 54);
      stall_word = -1;
      stall_len  = 0;

      $display("[TB] top-of-space block with re-request held while busy");
      push_fill(32'hFFFF_FFF0, 2'd1, 49);
      push_fill(32'h0000_ABC7, 2'd3, 49);
      @(negedge clk);
      fill_base = 32'hFFFF_FFF0;
      fill_sub  = 2'd1;
      fill_req  = 1'b1;
      wait_ack(20);
      @(negedge clk);
      no_ack    = 1'b1;
      fill_base = 32'h0000_ABC7;
      fill_sub  = 2'd3;
      wait_done(200);
      wait_ack(20);
      check_output("reaccept_after_done", ack_cycle > done_cycle, 1);
      @(negedge clk);
      fill_req = 1'b0;
      wait_done(200);

      $display("[TB] reset during word 7 WAIT");
      push_fill(32'h0000_2000, 2'd0, 49);
      @(negedge clk);
      fill_base = 32'h0000_2000;
      fill_sub  = 2'd0;
      fill_req  = 1'b1;
      wait_ack(20);
      @(negedge clk);
      fill_req = 1'b0;
      for (int i = 0; i < 100 && grant_idx < 8; i++) @(posedge clk);
      check_output("reached_word7", grant_idx, 8);
      #2;
      grst     = 1'b0;
      fill_req = 1'b1;
      #1;
      check_output("async_reset_outputs",
                   {flash_req, flash_addr, sram_we, sram_sel, sram_waddr, sram_wdata,
                    fill_ack, fill_done, fill_err, busy}, 0);
      check_output("writes_before_reset", exp_wr.size(), 9);
      check_output("reads_before_reset", exp_addr.size(), 8);
      exp_wr.delete();
      exp_addr.delete();
      exp_done.delete();
      begin
         int dones_before;
         dones_before = n_dones;
         repeat (3) @(negedge clk);
         fill_req = 1'b0;
         grst     = 1'b1;
         repeat (3) @(negedge clk);
         check_output("no_done_after_reset", n_dones - dones_before, 0);
      end
      apply_stimulus(32'h0000_5A5F, 2'd3, 49);

`ifdef REFILL_TIMEOUT_EN
      $display("[TB] timeout with word 0 never returned");
      exp_addr.push_back(32'h0000_3000);
      exp_done.push_back('{err: 1'b1, lat: 10});
      drop_rvalid = 1'b1;
      @(negedge clk);
      fill_base = 32'h0000_3000;
      fill_sub  = 2'd2;
      fill_req  = 1'b1;
      wait_ack(20);
      @(negedge clk);
      fill_req = 1'b0;
      wait_done(100);
      drop_rvalid = 1'b0;
`endif

      repeat (3) @(negedge clk);
      check_output("leftover_writes", exp_wr.size(), 0);
      check_output("leftover_dones", exp_done.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/sub_refill.md
SUB_REFILL -- requirements
Module: sub_refill

Interface
REQ-001 Parameter ADDR_W, default 32, meaning flash word-address width.
REQ-002 Parameter DATA_W, default 32, meaning flash/SRAM data width.
REQ-003 Parameter SUB_DEPTH, default 16, meaning words per sub-SRAM (power of two, >=2).
REQ-004 Parameter SUB_SEL_W, default 2, meaning sub-SRAM index width.
REQ-005 Parameter TIMEOUT, default 255, meaning max idle cycles waiting on flash (used only with REFILL_TIMEOUT_EN).
REQ-006 Port clk  input  1  the only clock; all logic on its rising edge.
REQ-007 Port grst  input  1  asynchronous, active-low reset.
REQ-008 Port fill_req  input  1  controller requests a sub-SRAM refill; held until fill_ack.
REQ-009 Port fill_base  input  ADDR_W  flash word address of the block to load.
REQ-010 Port fill_sub  input  SUB_SEL_W  victim sub-SRAM index.
REQ-011 Port fill_ack  output  1  one-cycle pulse: request accepted.
REQ-012 Port fill_done  output  1  one-cycle pulse: refill finished.
REQ-013 Port fill_err  output  1  valid with fill_done; 1 = aborted by timeout.
REQ-014 Port busy  output  1  high from acceptance until fill_done inclusive.
REQ-015 Port flash_req / flash_addr  output  1 / ADDR_W  flash read request and word address.
REQ-016 Port flash_gnt  input  1  flash accepts the current request.
REQ-017 Port flash_rvalid / flash_rdata  input  1 / DATA_W  read data return, one beat per granted request.
REQ-018 Port sram_we / sram_sel / sram_waddr / sram_wdata  output  1 / SUB_SEL_W / log2(SUB_DEPTH) / DATA_W  sub-SRAM write port.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, WRITE, DONE; IDLE on reset.
REQ-020 IDLE with fill_req=1: pulse fill_ack, latch fill_base with low log2(SUB_DEPTH) bits forced to zero, latch fill_sub, clear word counter k, go to ISSUE next cycle.
REQ-021 ISSUE: flash_req=1, flash_addr=base+k held stable until flash_gnt=1; on grant go to WAIT.
REQ-022 WAIT: flash_rvalid=1 in the grant cycle or later SHALL capture flash_rdata and go to WRITE; rvalid during ISSUE/IDLE ignored.
REQ-023 WRITE: exactly one cycle of sram_we=1, sram_sel=latched fill_sub, sram_waddr=k, sram_wdata=captured data; k<SUB_DEPTH-1 -> increment k, ISSUE; k=SUB_DEPTH-1 -> DONE.
REQ-024 DONE: one cycle, fill_done=1, fill_err=0, then IDLE; fill_req may be re-accepted no earlier than the cycle after DONE.
REQ-025 Only one outstanding flash request at any time; minimum refill time with zero-wait flash SHALL be 3*SUB_DEPTH+1 cycles from fill_ack to fill_done.
REQ-026 Address arithmetic SHALL wrap modulo 2^ADDR_W; k wraps never (terminates at SUB_DEPTH-1).
REQ-027 fill_req, fill_base, fill_sub changes while busy SHALL be ignored.
REQ-028 Outside ISSUE flash_req=0; outside WRITE sram_we=0; fill_ack only in accepting IDLE cycle.

Reset
REQ-029 grst=0 SHALL asynchronously force IDLE, k=0, and all outputs to 0 (flash_addr, sram_* buses included).
REQ-030 Reset mid-refill SHALL abandon the refill with no fill_done; partially written sub-SRAM contents are undefined to the controller.
REQ-031 Deassertion: first request accepted no earlier than the first rising edge after grst=1.

Configuration
REQ-032 Macro REFILL_TIMEOUT_EN defined: counter counts cycles in ISSUE/WAIT, cleared on each grant and each rvalid; reaching TIMEOUT -> DONE with fill_done=1, fill_err=1, no further sram_we.
REQ-033 Macro REFILL_TIMEOUT_EN undefined: no counter; block waits indefinitely; fill_err tied 0.

Verification
REQ-034 Zero-wait flash, fill_base=0x0000_1234, fill_sub=2 -> flash_addr 0x1230..0x123F in order, 16 sram_we with sram_sel=2, waddr 0..15, fill_done exactly 49 cycles after fill_ack.
REQ-035 flash_gnt delayed 5 cycles on word 3 -> flash_req/flash_addr=base+3 held stable all 5 cycles, single write of word 3.
REQ-036 fill_base=0xFFFF_FFF0 -> last address 0xFFFF_FFFF, no wrap into k; new fill_req during busy -> no fill_ack until after fill_done.
REQ-037 grst=0 asserted during word 7 WAIT -> all outputs 0 asynchronously, no fill_done, next fill_req after release completes normally.
REQ-038 REFILL_TIMEOUT_EN, TIMEOUT=8, flash_rvalid never returned for word 0 -> fill_done=1, fill_err=1 after 8 cycles in WAIT, zero sram_we pulses.
